// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the two-port SRAM arbiter.
// Holds the arbiter state encoding plus default address, data and burst widths.
package sram_arb_pkg;

    localparam int SRAM_ARB_AW        = 10;
    localparam int SRAM_ARB_DW        = 32;
    localparam int SRAM_ARB_MAX_BURST = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Round-robin tie-break: remembers the last granted port, and the other port wins a tie.
// Latency: pick is combinational; the pointer updates on the cycle after a grant is held.
// Backpressure: none; this block only advises the arbiter FSM.
module sram_arb_rr_pick
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic gnt_vld,
    input  logic gnt_id,
    output logic pick
);

    logic last;

    // Reset points at port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (gnt_vld) begin
            last <= gnt_id;
        end
    end

    assign pick = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/sram_arb_2x.sv
// Two-port arbiter onto one single-port SRAM; SRAM_ARB_RR_EN adds round-robin ties and MAX_BURST switching.
// Latency: beats issue combinationally in the grant cycle, and read data returns one cycle later.
// Backpressure: readyN is low while idle or while the other port holds the grant.
module sram_arb_2x
    import sram_arb_pkg::*;
#(
    parameter int AW        = SRAM_ARB_AW,
    parameter int DW        = SRAM_ARB_DW,
    parameter int MAX_BURST = SRAM_ARB_MAX_BURST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ready0,
    output logic          ready1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    output logic          sram_we,
    input  logic [DW-1:0] sram_dout
);

    // A value outside 1..15 would wrap the 4-bit beat counter.
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("sram_arb_2x: MAX_BURST must be within 1..15");
    end

    arb_state_t    state, state_nxt;
    logic          acc0, acc1, beat, pick, burst_end;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;

    assign acc0   = (state == GNT0) && req0;
    assign acc1   = (state == GNT1) && req1;
    assign beat   = acc0 || acc1;
    assign ready0 = acc0;
    assign ready1 = acc1;
    assign rdata  = sram_dout;

`ifdef SRAM_ARB_RR_EN
    logic [3:0] cnt, cnt_inc;

    assign cnt_inc   = cnt + 4'd1;
    assign burst_end = beat && (cnt_inc == 4'(MAX_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if ((state_nxt != state) || burst_end) begin
            cnt <= 4'd0;
        end else if (beat) begin
            cnt <= cnt_inc;
        end
    end

    sram_arb_rr_pick u_rr_pick (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .gnt_vld (state != IDLE),
        .gnt_id  (state == GNT1),
        .pick    (pick)
    );
`else
    assign burst_end = 1'b0;
    assign pick      = ~req0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A grant ends when its requester goes quiet, or when a burst ends and the other side is waiting.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req0 || req1) state_nxt = pick ? GNT1 : GNT0;
            GNT0: if (!req0 || (burst_end && req1)) state_nxt = req1 ? GNT1 : IDLE;
            GNT1: if (!req1 || (burst_end && req0)) state_nxt = req0 ? GNT0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sram_addr = addr_q;
        sram_din  = din_q;
        sram_we   = 1'b1;
        if (acc0) begin
            sram_addr = addr0;
            sram_din  = wdata0;
            sram_we   = ~wr0;
        end else if (acc1) begin
            sram_addr = addr1;
            sram_din  = wdata1;
            sram_we   = ~wr1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            din_q   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            if (beat) begin
                addr_q <= sram_addr;
                din_q  <= sram_din;
            end
            rvalid0 <= acc0 && !wr0;
            rvalid1 <= acc1 && !wr1;
        end
    end

endmodule

// File: tb/tb_sram_arb_2x.sv
// Directed bench for sram_arb_2x with a behavioural synchronous SRAM model.
// Covers both the fixed-priority build and the SRAM_ARB_RR_EN build.
module tb_sram_arb_2x;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ready0, ready1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;
    logic          sram_we;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem   [1024];
    bit            wrote [1024];

    always #5 clk = ~clk;

    sram_arb_2x #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .wr0       (wr0),
        .wr1       (wr1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ready0    (ready0),
        .ready1    (ready1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_we   (sram_we),
        .sram_dout (sram_dout)
    );

    // Unwritten locations read back as an address-derived pattern.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    always @(posedge clk) begin
        if (!sram_we) begin
            mem[sram_addr]   <= sram_din;
            wrote[sram_addr] <= 1'b1;
        end
        sram_dout <= wrote[sram_addr] ? mem[sram_addr] : pat(sram_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int g, gp;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        g = 0; gp = 0;

        #2;
        chk("rst_ready0", ready0, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_we", sram_we, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_din", sram_din, 0);
        tick;
        tick;
        rst = 1'b0;

        // Port 0 writes 0x005 then reads it back with no bubble between beats.
        req0 = 1'b1; wr0 = 1'b1; addr0 = 10'h005; wdata0 = 32'hDEAD_BEEF;
        #1;
        chk("wr_idle_ready0", ready0, 0);
        chk("wr_idle_we", sram_we, 1);
        tick;
        chk("wr_ready0", ready0, 1);
        chk("wr_we", sram_we, 0);
        chk("wr_addr", sram_addr, 10'h005);
        chk("wr_din", sram_din, 32'hDEAD_BEEF);
        tick;
        wr0 = 1'b0;
        #1;
        chk("rd_ready0", ready0, 1);
        chk("rd_we", sram_we, 1);
        chk("rd_no_rvalid_wr", rvalid0, 0);
        tick;
        req0 = 1'b0;
        #1;
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rvalid1", rvalid1, 0);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);
        chk("hold_addr", sram_addr, 10'h005);
        chk("hold_din", sram_din, 32'hDEAD_BEEF);
        chk("hold_we", sram_we, 1);
        tick;
        chk("rd_rvalid0_clr", rvalid0, 0);

        // Port 1 writes and reads the top address.
        req1 = 1'b1; wr1 = 1'b1; addr1 = 10'h3FF; wdata1 = 32'h1234_5678;
        #1;
        chk("top_idle_we", sram_we, 1);
        chk("top_idle_ready1", ready1, 0);
        tick;
        chk("top_wr_ready1", ready1, 1);
        chk("top_wr_we", sram_we, 0);
        chk("top_wr_addr", sram_addr, 10'h3FF);
        tick;
        wr1 = 1'b0;
        #1;
        chk("top_rd_we", sram_we, 1);
        tick;
        req1 = 1'b0;
        #1;
        chk("top_rvalid1", rvalid1, 1);
        chk("top_rvalid0", rvalid0, 0);
        chk("top_rdata", rdata, 32'h1234_5678);
        tick;
        chk("top_after_we", sram_we, 1);

        // Port 1 alone streams ten reads across the burst boundary.
        req1 = 1'b1; wr1 = 1'b0; addr1 = 10'h100;
        tick;
        for (int i = 0; i < 10; i++) begin
            addr1 = 10'h100 + 10'(i);
            #1;
            chk("solo_ready1", ready1, 1);
            if (i > 0) begin
                chk("solo_rvalid1", rvalid1, 1);
                chk("solo_rdata", rdata, pat(10'h100 + 10'(i - 1)));
            end
            tick;
        end
        req1 = 1'b0;
        #1;
        chk("solo_last_rvalid1", rvalid1, 1);
        chk("solo_last_rdata", rdata, pat(10'h109));
        tick;

        // Both ports stream reads; the previous grant was port 1, so port 0 wins the tie.
        req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = 10'h010; addr1 = 10'h020;
        tick;
        for (int k = 0; k < 12; k++) begin
            addr0 = 10'h010 + 10'(k);
            addr1 = 10'h020 + 10'(k);
            #1;
`ifdef SRAM_ARB_RR_EN
            g = (k / 4) % 2;
`else
            g = 0;
`endif
            chk("tie_ready0", ready0, (g == 0) ? 1 : 0);
            chk("tie_ready1", ready1, (g == 1) ? 1 : 0);
            if (k > 0) begin
                chk("tie_rvalid0", rvalid0, (gp == 0) ? 1 : 0);
                chk("tie_rvalid1", rvalid1, (gp == 1) ? 1 : 0);
                chk("tie_rdata", rdata,
                    pat((gp == 0) ? 10'h010 + 10'(k - 1) : 10'h020 + 10'(k - 1)));
            end
            gp = g;
            tick;
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("tie_end_rvalid0", rvalid0, (gp == 0) ? 1 : 0);
        chk("tie_end_rvalid1", rvalid1, (gp == 1) ? 1 : 0);
        tick;

        // Reset lands while a read response is due: the response is dropped.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 10'h030;
        #1;
        chk("mid_idle_ready0", ready0, 0);
        tick;
        chk("mid_rd_ready0", ready0, 1);
        tick;
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid0", rvalid0, 0);
        chk("mid_rst_rvalid1", rvalid1, 0);
        chk("mid_rst_we", sram_we, 1);
        chk("mid_rst_ready0", ready0, 0);
        chk("mid_rst_addr", sram_addr, 0);
        tick;
        chk("mid_rst_rvalid0_b", rvalid0, 0);
        rst = 1'b0; req0 = 1'b0;
        tick;
        chk("post_rst_rvalid0", rvalid0, 0);
        chk("post_rst_ready0", ready0, 0);
        chk("post_rst_we", sram_we, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arb_2x.md
SRAM_ARB_2X -- requirements
Module: sram_arb_2x

Interface
REQ-001 SHALL have parameter AW, default 10, SRAM word-address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive beats per grant before a forced switch; legal range 1..15.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports req0/req1, input, 1 each, requester has a beat pending.
REQ-007 SHALL have ports wr0/wr1, input, 1 each: 1 = write beat, 0 = read beat.
REQ-008 SHALL have ports addr0/addr1, input, AW each, word address.
REQ-009 SHALL have ports wdata0/wdata1, input, DW each, write data.
REQ-010 SHALL have ports ready0/ready1, output, 1 each, beat accepted this cycle.
REQ-011 SHALL have ports rvalid0/rvalid1, output, 1 each, read data valid.
REQ-012 SHALL have port rdata, output, DW, read data shared by both requesters, qualified by rvalid0/rvalid1.
REQ-013 SHALL have ports sram_addr (output, AW), sram_din (output, DW), sram_we (output, 1, active-low write: 0 = write, 1 = read), and sram_dout (input, DW).

Function
REQ-014 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-015 IDLE -> GNT0/GNT1 when the corresponding req is high; if both are high, the winner SHALL be chosen per REQ-025.
REQ-016 In GNTn: readyn = reqn (combinational); the other ready = 0; in IDLE both ready = 0.
REQ-017 In GNTn with reqn high: sram_addr = addrn, sram_din = wdatan, sram_we = ~wrn, all combinational; one beat is issued per cycle.
REQ-018 With no accepted beat: sram_we = 1, and sram_addr and sram_din SHALL hold their last values.
REQ-019 Read latency: a read beat accepted in cycle N SHALL give rvalidn = 1 in cycle N+1, with rdata = sram_dout.
REQ-020 Writes SHALL produce no rvalid; rvalid0 and rvalid1 SHALL never both be 1.
REQ-021 A 4-bit beat counter SHALL increment on each accepted beat and clear on every grant change.
REQ-022 GNTn, reqn low: go to the other GNT if its req is high, else IDLE.
REQ-023 GNTn, counter reaches MAX_BURST on an accepted beat, other req high: switch to the other GNT next cycle.
REQ-024 GNTn, counter reaches MAX_BURST on an accepted beat, other req low: stay in GNTn and clear the counter.
REQ-025 Round-robin pointer: updated to the port last granted; on a tie, the port not last granted wins.
REQ-026 Back-to-back mixed read/write beats SHALL be allowed without bubbles; a read issued in a requester's last granted cycle SHALL still return rvalid to that requester.

Reset
REQ-027 During rst: state = IDLE, counter = 0, RR pointer = port 1 (so port 0 wins the first tie), rvalid0/1 = 0, ready0/1 = 0, sram_we = 1, sram_addr = 0, sram_din = 0.
REQ-028 A read in flight when rst asserts SHALL be dropped (no rvalid after reset).

Configuration
REQ-029 Macro SRAM_ARB_RR_EN defined: round-robin tie-break and the MAX_BURST forced switch SHALL be active.
REQ-030 Macro SRAM_ARB_RR_EN undefined: fixed priority with port 0 winning ties, no MAX_BURST limit, and a grant held until its req drops; the counter and pointer are not instantiated.

Structure
REQ-031 Shared package sram_arb_pkg SHALL hold the state enum (IDLE, GNT0, GNT1) and default constants AW = 10, DW = 32, MAX_BURST = 4.
REQ-032 The tie-break/pointer logic SHALL be a sub-module sram_arb_rr_pick; the FSM, counter and datapath mux stay in the top.

Verification
REQ-033 req0 write addr 0x005 data 0xDEADBEEF, then req0 read 0x005 -> sram_we = 0 then 1, rvalid0 = 1 one cycle after the read with rdata = 0xDEADBEEF.
REQ-034 req0 and req1 high from reset, continuous reads -> GNT0 for 4 beats, then GNT1 for 4 beats, alternating; no rvalid misrouted.
REQ-035 Only req1 continuous for 10 beats -> ready1 = 1 every cycle, no bubbles at the MAX_BURST boundary.
REQ-036 rst asserted the cycle after a read is accepted -> rvalid0/1 = 0 and sram_we = 1 immediately, FSM in IDLE.
REQ-037 With SRAM_ARB_RR_EN undefined, both ports requesting continuously -> port 1 never granted while req0 is high.
REQ-038 Write to addr 0x3FF then read 0x3FF -> correct data at the top address; sram_we = 1 in all idle cycles.
